// File: rtl/fft8_pkg.sv
// Shared constants and types for the 8-point FFT datapath and its spectrum readers.
package fft8_pkg;
  localparam int DW    = 32;
  localparam int NBINS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic is_last_bin(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NBINS - 1);
  endfunction
endpackage

// File: rtl/fft8_bin_mux.sv
// Selects one bin (real and imaginary word) out of a captured spectrum bank.
module fft8_bin_mux
  import fft8_pkg::*;
(
  input  logic signed [DW-1:0]    bank_re [NBINS],
  input  logic signed [DW-1:0]    bank_im [NBINS],
  input  logic        [IDX_W-1:0] idx,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im
);
  assign out_re = bank_re[idx];
  assign out_im = bank_im[idx];
endmodule

// File: rtl/fft8_unloader.sv
// Captures a parallel 8-bin spectrum on a handshake and streams it out one bin per beat.
module fft8_unloader
  import fft8_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NBINS*DW-1:0] xr_flat,
  input  logic [NBINS*DW-1:0] xi_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_re,
  output logic [DW-1:0]       out_im,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic [CNT_W-1:0]    frame_cnt
);
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic signed [DW-1:0]    bank_re_q [NBINS];
  logic signed [DW-1:0]    bank_im_q [NBINS];
  logic signed [DW-1:0]    bank_re_d [NBINS];
  logic signed [DW-1:0]    bank_im_d [NBINS];
  logic signed [DW-1:0]    mux_re, mux_im;
  logic                    beat_fire;
  logic                    capture;

  // in_ready is the only combinational output: a new frame may enter on the
  // very beat that retires bin 7, which is what removes the bubble.
  always_comb begin
    beat_fire = out_valid_q & out_ready;
    in_ready  = (state_q == IDLE) | (beat_fire & is_last_bin(idx_q));
    capture   = in_valid & in_ready;

    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    for (int k = 0; k < NBINS; k++) begin
      bank_re_d[k] = capture ? xr_flat[k*DW +: DW] : bank_re_q[k];
      bank_im_d[k] = capture ? xi_flat[k*DW +: DW] : bank_im_q[k];
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (beat_fire) begin
          if (!is_last_bin(idx_q)) begin
            idx_d = idx_q + 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            idx_d       = '0;
            state_d     = capture ? SEND : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == SEND);
    out_last_d  = (state_d == SEND) && is_last_bin(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < NBINS; k++) begin
        bank_re_q[k] <= '0;
        bank_im_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < NBINS; k++) begin
        bank_re_q[k] <= bank_re_d[k];
        bank_im_q[k] <= bank_im_d[k];
      end
    end
  end

  fft8_bin_mux u_bin_mux (
    .bank_re (bank_re_q),
    .bank_im (bank_im_q),
    .idx     (idx_q),
    .out_re  (mux_re),
    .out_im  (mux_im)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;
  assign out_re    = mux_re;
  assign out_im    = mux_im;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft8_unloader.sv
// Randomized bench for fft8_unloader with a queue-based model of the emitted beat stream.
module tb_fft8_unloader;
  localparam int DW = 32;
  localparam int NB = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NB*DW-1:0] xr_flat = '0;
  logic [NB*DW-1:0] xi_flat = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_re, out_im;
  logic [2:0]       out_idx;
  logic             out_last;
  logic [15:0]      frame_cnt;

  fft8_unloader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xr_flat(xr_flat), .xi_flat(xi_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
  } beat_t;

  beat_t         q[$];
  logic [15:0]   m_cnt = '0;
  bit            in_fire = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] obs_re0, obs_im0, obs_re7;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted frame appends 8 beats; every accepted beat retires the head.
  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    if (!rst_n) begin
      q.delete();
      m_cnt   = '0;
      in_fire = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_re", 64'(out_re), 64'd0);
      chk("rst_out_im", 64'(out_im), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    end else begin
      exp_v = (q.size() != 0);
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
        chk("out_re", 64'(out_re), 64'(q[0].re));
        chk("out_im", 64'(out_im), 64'(q[0].im));
        chk("out_idx", 64'(out_idx), 64'(q[0].idx));
        chk("out_last", 64'(out_last), 64'(q[0].idx == NB - 1));
      end
      exp_rdy = !exp_v || (out_ready && q[0].idx == NB - 1);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
      if (exp_v && out_ready) begin
        if (q[0].idx == 0) begin
          obs_re0 = out_re;
          obs_im0 = out_im;
        end
        if (q[0].idx == NB - 1) begin
          obs_re7 = out_re;
          m_cnt   = m_cnt + 16'd1;
        end
        void'(q.pop_front());
      end
      in_fire = in_valid && exp_rdy;
      if (in_fire) begin
        for (int k = 0; k < NB; k++) begin
          beat_t b;
          b.re  = xr_flat[k*DW +: DW];
          b.im  = xi_flat[k*DW +: DW];
          b.idx = k;
          q.push_back(b);
        end
      end
    end
  end

  task automatic new_frame(input bit pat);
    for (int k = 0; k < NB; k++) begin
      xr_flat[k*DW +: DW] = pat ? DW'(k + 1) : $urandom;
      xi_flat[k*DW +: DW] = pat ? -DW'(k + 1) : $urandom;
    end
  endtask

  // mode 0: out_ready=1, mode 1: pattern 1,0,0 repeating, mode 2: random
  task automatic run(input int frames, input int mode, input bit pat);
    int left = frames;
    int cyc  = 0;
    @(posedge clk); #1;
    new_frame(pat);
    in_valid = (left > 0);
    while (1) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      cyc++;
      if (in_fire) begin
        left--;
        new_frame(pat);
      end
      in_valid = (left > 0);
      if (left == 0 && q.size() == 0) break;
      if (cyc > 400) begin
        chk("run_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!out_valid) seen = 1'b1;
    end
    chk("wait_idle", 64'(seen), 64'd1);
  endtask

  initial begin
    logic [15:0] c0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a frame (bin 4 pending): frame dropped, count stays 0.
    @(posedge clk); #1;
    new_frame(1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // One known frame with out_ready held high.
    run(1, 0, 1'b1);
    chk("t1_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_bin0_re", 64'(obs_re0), 64'd1);
    chk("t1_bin0_im", 64'(obs_im0), 64'h0000_0000_FFFF_FFFF);
    chk("t1_bin7_re", 64'(obs_re7), 64'd8);
    chk("t1_idle", 64'(out_valid), 64'd0);

    // Stalled consumer.
    run(2, 1, 1'b0);
    chk("stall_cnt", 64'(frame_cnt), 64'd3);

    // Three back-to-back frames.
    c0 = frame_cnt;
    run(3, 0, 1'b0);
    chk("b2b_cnt", 64'(frame_cnt - c0), 64'd3);

    // in_valid raised at idx 3 and dropped at idx 5 is ignored.
    c0 = frame_cnt;
    @(posedge clk); #1;
    new_frame(1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midv_idx3", 64'(out_idx), 64'd3);
    new_frame(1'b0);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle(20);
    chk("midv_cnt", 64'(frame_cnt - c0), 64'd1);

    // Random traffic.
    run(6, 2, 1'b0);

    // Counter wrap from 0xFFFF.
    @(posedge clk); #1;
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    run(1, 0, 1'b0);
    chk("wrap_cnt", 64'(frame_cnt), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d vectors, expected completion", n_vec);
    $fatal(1);
  end
endmodule
